seq_divider: RTL



---
 rtl/seq_divider_pkg.sv | 16 +
 rtl/seq_divider_if.sv | 22 ++
 rtl/seq_divider_div_step.sv | 19 +
 rtl/seq_divider.sv | 130 +++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CHECK      = 3'd1,
        S_ITERATE    = 3'd2,
        S_FINISH     = 3'd3,
        S_ERROR_CASE = 3'd4,
        S_DONE       = 3'd5
    } state_e;

    // Sliced to WIDTH by the user; wide enough for any supported WIDTH.
    localparam logic [63:0] ERR_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_if.sv
// Start/Done handshake and operand/result bus of seq_divider.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 16
);
    logic                   Start;
    logic [2*WIDTH-1:0]     Dividend;
    logic [WIDTH-1:0]       Divisor;
    logic [WIDTH-1:0]       Quotient;
    logic [WIDTH-1:0]       Remainder;
    logic                   Error;
    logic                   Done;

    modport master (
        output Start, Dividend, Divisor,
        input  Quotient, Remainder, Error, Done
    );

    modport slave (
        input  Start, Dividend, Divisor,
        output Quotient, Remainder, Error, Done
    );
endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift {R,Q} left, subtract divisor when it fits.
module div_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH:0]   r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH:0]   r_o,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH:0] shifted;
    logic           fits;

    // R < Divisor on entry, so R's top bit is zero and drops out of the shift.
    assign shifted = {r_i[WIDTH-1:0], q_i[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, d_i});
    assign r_o     = fits ? (shifted - {1'b0, d_i}) : shifted;
    assign q_o     = {q_i[WIDTH-2:0], fits};
endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider (2W / W) with Start/Done handshake.
// Optional SEQ_DIVIDER_ZERO_SHORTCUT_EN: a zero dividend skips the iterations.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic        Clock,
    input  logic        Reset,
    seq_divider_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    state_e            state_q, state_d;
    logic [WIDTH:0]    r_q, r_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [WIDTH-1:0]  div_q, div_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  quot_q, quot_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [WIDTH:0]    step_r;
    logic [WIDTH-1:0]  step_q;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (div_q),
        .r_o (step_r),
        .q_o (step_q)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    // Operands are loaded straight into the working {R,Q} pair.
                    r_d     = {1'b0, bus.Dividend[2*WIDTH-1:WIDTH]};
                    q_d     = bus.Dividend[WIDTH-1:0];
                    div_d   = bus.Divisor;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (div_q == '0) begin
                    state_d = S_ERROR_CASE;
                end else if (r_q[WIDTH-1:0] >= div_q) begin
                    state_d = S_ERROR_CASE;
`ifdef SEQ_DIVIDER_ZERO_SHORTCUT_EN
                end else if ((r_q == '0) && (q_q == '0)) begin
                    state_d = S_FINISH;
`endif
                end else begin
                    cnt_d   = '0;
                    state_d = S_ITERATE;
                end
            end
            S_ITERATE: begin
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: begin
                quot_d  = q_q;
                rem_d   = r_q[WIDTH-1:0];
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_ERROR_CASE: begin
                quot_d  = ERR_QUOTIENT[WIDTH-1:0];
                rem_d   = '0;
                err_d   = 1'b1;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!bus.Start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            q_q     <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.Quotient  = quot_q;
    assign bus.Remainder = rem_q;
    assign bus.Done      = done_q;
    assign bus.Error     = err_q;
endmodule
